// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the register-file writeback
//                arbiter: destination-address width, queued request layout
//                and the grant encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    // Register-file address width (32 architectural registers)
    localparam int REG_AW  = 5;
    // Nominal writeback data width used by the request record
    localparam int WB_XLEN = 64;

    // One queued writeback: destination register and value
    typedef struct packed {
        logic [REG_AW-1:0]  rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

    // Which source owns the write port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } wb_gnt_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO for queued writeback requests. Push and pop
//                in the same cycle are allowed; a push while full or a pop
//                while empty is ignored so the queue can never corrupt itself.
//                The head entry is presented combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int WIDTH = 69,
    parameter  int DEPTH = 4,
    localparam int c_AW  = $clog2(DEPTH),
    localparam int c_CW  = c_AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [c_CW-1:0]  o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == c_CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rptr];

    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop  && !o_empty;

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file's single write port between the
//                single-cycle ALU path (port 0, unbuffered) and the
//                long-latency path (port 1, queued). Port 0 has fixed
//                priority; a port-1 head that keeps losing is forced through
//                after STARVE_LIMIT lost arbitrations. The write port outputs
//                are registered (one cycle after the grant).
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p0_valid,
    output logic                          p0_ready,
    input  logic [REG_AW-1:0]             p0_rd,
    input  logic [XLEN-1:0]               p0_data,
    input  logic                          p1_valid,
    output logic                          p1_ready,
    input  logic [REG_AW-1:0]             p1_rd,
    input  logic [XLEN-1:0]               p1_data,
    output logic                          wb_we,
    output logic [REG_AW-1:0]             wb_addr,
    output logic [XLEN-1:0]               wb_data,
    output logic [$clog2(FIFO_DEPTH):0]   p1_count
);

    localparam int             c_ENT_W      = REG_AW + XLEN;
    localparam int             c_SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    wb_gnt_e            w_gnt;
    logic               w_hv;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;
    logic [REG_AW-1:0]  w_head_rd;
    logic [XLEN-1:0]    w_head_data;

    logic [c_SW-1:0]    r_starve;
    logic               r_wb_we;
    logic [REG_AW-1:0]  r_wb_addr;
    logic [XLEN-1:0]    r_wb_data;

    assign w_hv        = !w_empty;
    assign w_head_rd   = w_head[c_ENT_W-1 -: REG_AW];
    assign w_head_data = w_head[XLEN-1:0];

    // Writes to x0 are architecturally void: they are accepted without ever
    // touching the port (port 0) or the queue (port 1).
    assign p0_ready = !rst && ((w_gnt == GNT_P0) || (p0_rd == '0));
    assign p1_ready = !rst && ((p1_rd == '0) || !w_full);
    assign w_push   = p1_valid && p1_ready && (p1_rd != '0);
    assign w_pop    = (w_gnt == GNT_P1);

    wb_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({p1_rd, p1_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (p1_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Fixed priority to the ALU path, overridden once the queued head has starved
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_hv && (r_starve == c_STARVE_MAX)) begin
            w_gnt = GNT_P1;
        end else if (p0_valid && (p0_rd != '0)) begin
            w_gnt = GNT_P0;
        end else if (w_hv) begin
            w_gnt = GNT_P1;
        end
    end

    // Count consecutive losses of a waiting head; any pop or empty queue restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_hv || w_pop) begin
            r_starve <= '0;
        end else if (r_starve != c_STARVE_MAX) begin
            r_starve <= r_starve + c_SW'(1);
        end
    end

    // Register the winning request onto the write port; idle keeps addr/data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            case (w_gnt)
                GNT_P0: begin
                    r_wb_we   <= 1'b1;
                    r_wb_addr <= p0_rd;
                    r_wb_data <= p0_data;
                end
                GNT_P1: begin
                    r_wb_we   <= 1'b1;
                    r_wb_addr <= w_head_rd;
                    r_wb_data <= w_head_data;
                end
                default: begin
                    r_wb_we   <= 1'b0;
                end
            endcase
        end
    end

    assign wb_we   = r_wb_we;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed, self-checking bench for regfile_wb_arbiter. Each
//                stimulus step queues the write it should produce; a monitor
//                on the falling edge pops and compares every write-port pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN         = 64;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            p0_valid;
    logic            p0_ready;
    logic [4:0]      p0_rd;
    logic [XLEN-1:0] p0_data;
    logic            p1_valid;
    logic            p1_ready;
    logic [4:0]      p1_rd;
    logic [XLEN-1:0] p1_data;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [CW-1:0]   p1_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN         (XLEN),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p0_ready (p0_ready),
        .p0_rd    (p0_rd),
        .p0_data  (p0_data),
        .p1_valid (p1_valid),
        .p1_ready (p1_ready),
        .p1_rd    (p1_rd),
        .p1_data  (p1_data),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .p1_count (p1_count)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [63:0] d1);
        p0_valid = v0;
        p0_rd    = r0;
        p0_data  = d0;
        p1_valid = v1;
        p1_rd    = r1;
        p1_data  = d1;
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every write-port pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (wb_we !== 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got we=%b addr=%0d data=0x%0h, expected no write",
                         wb_we, wb_addr, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_addr", 64'(wb_addr), 64'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        // 1. Reset held two cycles with a live ALU request
        rst = 1'b1;
        drv(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0);
        #2;
        chk("rst_p0_ready", 64'(p0_ready), 64'd0);
        chk("rst_p1_ready", 64'(p1_ready), 64'd0);
        cyc();
        chk("rst2_p0_ready", 64'(p0_ready), 64'd0);
        chk("rst2_p1_ready", 64'(p1_ready), 64'd0);
        cyc();
        rst = 1'b0;
        chk("post_rst_wb_we",   64'(wb_we),    64'd0);
        chk("post_rst_wb_addr", 64'(wb_addr),  64'd0);
        chk("post_rst_wb_data", wb_data,       64'd0);
        chk("post_rst_count",   64'(p1_count), 64'd0);

        // 2. Single ALU write with an empty queue
        drv(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t2_p0_ready", 64'(p0_ready), 64'd1);
        exp_wb(5'd5, 64'hDEAD);

        // 3. One queued entry against a saturating ALU stream
        cyc();
        drv(1'b1, 5'd3, 64'h300, 1'b1, 5'd7, 64'd1);
        #1;
        chk("t3_p1_ready", 64'(p1_ready), 64'd1);
        chk("t3_p0_ready", 64'(p0_ready), 64'd1);
        exp_wb(5'd3, 64'h300);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            drv(1'b1, 5'd3, 64'h300 + 64'(i), 1'b0, 5'd0, 64'd0);
            #1;
            chk("t3_p0_wins", 64'(p0_ready), 64'd1);
            exp_wb(5'd3, 64'h300 + 64'(i));
        end
        cyc();
        drv(1'b1, 5'd3, 64'h304, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t3_head_forced", 64'(p0_ready), 64'd0);
        exp_wb(5'd7, 64'd1);
        cyc();
        drv(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t3_count_empty", 64'(p1_count), 64'd0);

        // 4. Fill the queue to capacity while the ALU saturates, then drain in order
        for (int i = 0; i < 4; i++) begin
            cyc();
            drv(1'b1, 5'd3, 64'h400 + 64'(i), 1'b1, 5'(8 + i), 64'h800 + 64'(i));
            #1;
            chk("t4_p1_ready", 64'(p1_ready), 64'd1);
            exp_wb(5'd3, 64'h400 + 64'(i));
        end
        cyc();
        drv(1'b1, 5'd3, 64'h404, 1'b1, 5'd12, 64'hC00);
        #1;
        chk("t4_full_count",    64'(p1_count), 64'd4);
        chk("t4_full_p1_ready", 64'(p1_ready), 64'd0);
        chk("t4_head_forced",   64'(p0_ready), 64'd0);
        exp_wb(5'd8, 64'h800);
        for (int e = 1; e <= 3; e++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                drv(1'b1, 5'd3, 64'h410 + 64'(e * 4 + k), 1'b0, 5'd0, 64'd0);
                #1;
                chk("t4_p0_wins", 64'(p0_ready), 64'd1);
                exp_wb(5'd3, 64'h410 + 64'(e * 4 + k));
            end
            cyc();
            drv(1'b1, 5'd3, 64'h4FF, 1'b0, 5'd0, 64'd0);
            #1;
            chk("t4_head_forced", 64'(p0_ready), 64'd0);
            exp_wb(5'(8 + e), 64'h800 + 64'(e));
        end
        cyc();
        drv(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t4_count_empty", 64'(p1_count), 64'd0);

        // 5. x0 requests on both ports: accepted, never written; head goes same cycle
        cyc();
        drv(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99);
        #1;
        chk("t5_p1_ready", 64'(p1_ready), 64'd1);
        cyc();
        drv(1'b1, 5'd0, 64'hBAD, 1'b1, 5'd0, 64'hBAD1);
        #1;
        chk("t5_p0_x0_ready", 64'(p0_ready), 64'd1);
        chk("t5_p1_x0_ready", 64'(p1_ready), 64'd1);
        exp_wb(5'd9, 64'h99);
        cyc();
        drv(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t5_count_empty", 64'(p1_count), 64'd0);

        // 6. Three queued entries discarded by a one-cycle reset
        for (int i = 0; i < 3; i++) begin
            cyc();
            drv(1'b1, 5'd3, 64'h600 + 64'(i), 1'b1, 5'(20 + i), 64'h2000 + 64'(i));
            exp_wb(5'd3, 64'h600 + 64'(i));
        end
        cyc();
        drv(1'b1, 5'd3, 64'h603, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t6_count3", 64'(p1_count), 64'd3);
        exp_wb(5'd3, 64'h603);
        cyc();
        rst = 1'b1;
        drv(1'b1, 5'd3, 64'h604, 1'b1, 5'd23, 64'h2003);
        #1;
        chk("t6_rst_p0_ready", 64'(p0_ready), 64'd0);
        chk("t6_rst_p1_ready", 64'(p1_ready), 64'd0);
        cyc();
        rst = 1'b0;
        drv(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("t6_count_cleared", 64'(p1_count), 64'd0);
        chk("t6_wb_we_cleared", 64'(wb_we),    64'd0);
        repeat (6) cyc();
        chk("all_writes_seen", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
